// File: rtl/not16_link_pkg.sv
// Shared definitions for the inverted-line word link: line levels, FSM states,
// and the polarity rule (each line bit is the complement of its data bit).
package not16_link_pkg;
  localparam int   DATA_W    = 16;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [DATA_W-1:0] line_of(input logic [DATA_W-1:0] d);
    return ~d;
  endfunction
endpackage

// File: rtl/not16.sv
// Bitwise 16-bit inverter; the same cell the transmitter uses to drive the line.
module not16
  import not16_link_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] y
);
  assign y = line_of(a);
endmodule

// File: rtl/not16_link_rx.sv
// Bit-serial receiver: start detect, mid-bit sampling of 16 inverted data bits,
// stop check, and a one-deep valid/ready output with sticky overrun.
module not16_link_rx #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_line,
  input  logic              out_ready,
  input  logic              clear_err,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  import not16_link_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W);

  state_t            state, state_nx;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] raw, word;
  logic              tick_half, tick_full, last_bit;
  logic              cnt_clr, data_smp, stop_smp;
  logic              word_done, load, xfer;

  assign tick_half = (clk_cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign tick_full = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_idx == BW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rx_line == START_LVL) state_nx = START;
      START:   if (tick_half) state_nx = (rx_line == START_LVL) ? DATA : IDLE;
      DATA:    if (tick_full && last_bit) state_nx = STOP;
      STOP:    if (tick_full) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    data_smp = 1'b0;
    stop_smp = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE:    begin cnt_clr = 1'b1; busy = 1'b0; end
      START:   cnt_clr = tick_half;
      DATA:    begin cnt_clr = tick_full; data_smp = tick_full; end
      STOP:    begin cnt_clr = tick_full; stop_smp = tick_full; end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) clk_cnt <= '0;
    else                  clk_cnt <= clk_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || state != DATA) bit_idx <= '0;
    else if (data_smp)          bit_idx <= bit_idx + BW'(1);
  end

  // raw keeps line polarity; the inverter restores the true word
  always_ff @(posedge clk) begin
    if (reset)         raw <= '0;
    else if (data_smp) raw[bit_idx] <= rx_line;
  end

  not16 u_not16 (.a(raw), .y(word));

  assign word_done = stop_smp && (rx_line == STOP_LVL);
  assign xfer      = out_valid && out_ready;
  assign load      = word_done && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_smp && (rx_line != STOP_LVL);
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      // a fresh drop outranks a simultaneous clear
      if (word_done && !load) overrun <= 1'b1;
      else if (clear_err)     overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_not16_link_rx.sv
// Bench for not16_link_rx: directed frames plus random traffic, checked every
// cycle against a transaction-level model driven by the frame schedule.
module tb_not16_link_rx;
  localparam int C = 4;
  localparam int H = C / 2;

  logic        clk = 1'b0, reset = 1'b1, rx_line = 1'b1, out_ready = 1'b0, clear_err = 1'b0;
  logic [15:0] out_data;
  logic        out_valid, frame_err, overrun, busy;

  not16_link_rx #(.DATA_W(16), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx_line(rx_line), .out_ready(out_ready),
    .clear_err(clear_err), .out_data(out_data), .out_valid(out_valid),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int t; logic [15:0] d; bit good;} comp_t;
  comp_t comp_q[$];
  comp_t cq;
  int    cyc = 0, b_lo = -1, b_hi = -2;
  int    checks = 0, failures = 0;
  bit    chk_en = 1'b0;
  logic [15:0] m_data = '0;
  bit    m_valid = 0, m_ferr = 0, m_ovr = 0, m_busy = 0;
  int    cur;
  bit    m_done, m_good, m_set;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Model: a word completes at its scheduled stop-sample cycle; outputs follow next cycle.
  always @(posedge clk) begin
    cur = cyc;
    cyc = cyc + 1;
    if (reset) begin
      m_valid = 0; m_data = '0; m_ferr = 0; m_ovr = 0; m_busy = 0;
      comp_q.delete();
    end else begin
      m_done = 0; m_good = 0;
      if (comp_q.size() > 0 && comp_q[0].t == cur) begin
        cq = comp_q.pop_front();
        m_done = 1; m_good = cq.good;
      end
      m_ferr = m_done && !m_good;
      m_set  = 0;
      if (m_done && m_good) begin
        if (!m_valid || out_ready) begin m_data = cq.d; m_valid = 1; end
        else m_set = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (m_set) m_ovr = 1;
      else if (clear_err) m_ovr = 0;
      m_busy = (cur + 1 >= b_lo) && (cur + 1 <= b_hi);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", out_valid, m_valid);
      chk("data", out_data, m_data);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int k);
    int n;
    n = 0;
    while (cyc < k && n < 10000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != k) chk("wait_cycle", cyc, k);
    @(negedge clk);
  endtask

  // Drives one frame starting this cycle; abort_bit >= 0 pulses reset mid data bit.
  task automatic send_frame(input logic [15:0] w, input bit stop_ok, input int abort_bit);
    int s;
    s = cyc;
    if (abort_bit < 0) comp_q.push_back('{s + H + 17*C, w, stop_ok});
    b_lo = s + 1;
    b_hi = s + H + 17*C;
    rx_line = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 16; i++) begin
      rx_line = ~w[i];
      if (i == abort_bit) begin
        repeat (H) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rx_line = 1'b1;
        b_hi = cyc - 1;
        return;
      end
      repeat (C) tick();
    end
    if (stop_ok) begin
      rx_line = 1'b1;
      repeat (C) tick();
    end else begin
      rx_line = 1'b0;
      repeat (H + 1) tick();
      rx_line = 1'b1;
      repeat (C - H - 1) tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int t, s;
  bit done;
  logic [15:0] rw;
  bit rok;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // basic word, consumer always ready
    out_ready = 1'b1;
    t = cyc + H + 17*C;
    fork
      send_frame(16'hA5C3, 1'b1, -1);
      begin
        at_neg(t);
        chk("t1_before", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 16'hA5C3);
        @(negedge clk);
        chk("t1_pulse", out_valid, 0);
      end
    join
    tick();

    // one-clock glitch is a false start
    s = cyc;
    b_lo = s + 1;
    b_hi = s + H;
    rx_line = 1'b0;
    tick();
    rx_line = 1'b1;
    at_neg(s + 1);
    chk("glitch_busy", busy, 1);
    at_neg(s + H + 1);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", out_valid, 0);
    chk("glitch_ferr", frame_err, 0);
    repeat (4) tick();

    // bad stop bit, then a good frame
    t = cyc + H + 17*C;
    fork
      send_frame(16'h1234, 1'b0, -1);
      begin
        at_neg(t + 1);
        chk("ferr_pulse", frame_err, 1);
        chk("ferr_novalid", out_valid, 0);
        @(negedge clk);
        chk("ferr_once", frame_err, 0);
      end
    join
    tick();
    t = cyc + H + 17*C;
    fork
      send_frame(16'hFFFF, 1'b1, -1);
      begin
        at_neg(t + 1);
        chk("after_ferr_valid", out_valid, 1);
        chk("after_ferr_data", out_data, 16'hFFFF);
      end
    join
    tick();

    // overrun with a stalled consumer
    out_ready = 1'b0;
    tick();
    send_frame(16'h0001, 1'b1, -1);
    send_frame(16'h8000, 1'b1, -1);
    tick();
    @(negedge clk);
    chk("ovr_data", out_data, 16'h0001);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_flag", overrun, 1);
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", overrun, 0);
    tick();

    // ready arrives exactly on the completion cycle
    t = cyc + H + 17*C;
    fork
      send_frame(16'h8000, 1'b1, -1);
      begin
        while (cyc < t) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("coinc_valid", out_valid, 1);
        chk("coinc_data", out_data, 16'h8000);
        chk("coinc_ovr", overrun, 0);
      end
    join
    out_ready = 1'b1;
    repeat (2) tick();

    // reset mid-frame, then a clean frame
    send_frame(16'h00FF, 1'b1, 7);
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ferr", frame_err, 0);
    chk("abort_ovr", overrun, 0);
    tick();
    t = cyc + H + 17*C;
    fork
      send_frame(16'h5A5A, 1'b1, -1);
      begin
        at_neg(t + 1);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 16'h5A5A);
      end
    join

    // random back-to-back traffic with random ready and clear
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 14; k++) begin
          rw  = 16'($urandom);
          rok = ($urandom_range(0, 5) != 0);
          send_frame(rw, rok, -1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          clear_err = ($urandom_range(0, 9) == 0);
          tick();
        end
      end
    join
    clear_err = 1'b0;
    out_ready = 1'b1;
    repeat (4 * C) tick();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
